// File: rtl/uart_rx_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_pkg
// Purpose  : Shared definitions for the UART receive path: receiver state
//            encodings, the half-bit offset used to centre the start-bit
//            sample, and the parity function shared with the transmit side.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_frame_pkg;

  // Number of data bits carried by one frame.
  localparam int DATA_BITS = 8;

  // Receiver states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PAR       = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  // Offset from the detected falling edge to the middle of the start bit.
  function automatic int unsigned half_count(input int unsigned timer);
    return timer / 2;
  endfunction

  // Parity bit a transmitter appends to 'data'.
  // odd_sense = 0 gives ^data, odd_sense = 1 gives ~^data.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                      input logic                 odd_sense);
    return odd_sense ? ~^data : ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_frame_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for an asynchronous UART input. Both
//            flops reset to 1 so an idle-high line never shows a spurious
//            falling edge when reset is released.
// Ports    : clk   - clock
//            reset - synchronous, active-high reset
//            d     - asynchronous input
//            q     - synchronized output (2 cycles of latency)
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Purpose  : UART receive stage. Synchronizes the serial line, recovers one
//            8-bit frame (optional parity, 1 or 2 stop bits) at TIMER clocks
//            per bit, checks parity/framing/break, and presents the byte in a
//            one-deep holding register consumed by a one-cycle rd pulse.
// Params   : P        - 1 = a parity bit follows the data
//            EVEN_ODD - expected parity: 0 -> ^data, 1 -> ~^data
//            s        - stop bits (1 or 2)
//            TIMER    - clocks per bit (>= 8)
// Ports    : clk, reset   - clock, synchronous active-high reset
//            tdi          - asynchronous serial input, idle high
//            rd           - consume the held byte (one-cycle pulse)
//            dout         - held byte, LSB received first
//            valid        - dout holds an unconsumed byte
//            parity_err   - parity mismatch on the held byte
//            frame_err    - a stop bit of the held byte sampled 0
//            overrun      - sticky: a frame was dropped while valid was set
//            brk          - held frame was a break (all bits 0)
//            rx_tick      - one-cycle pulse per completed frame
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int P        = 0,
  parameter int EVEN_ODD = 0,
  parameter int s        = 1,
  parameter int TIMER    = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tdi,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       brk,
  output logic       rx_tick
);

  localparam int              TW        = $clog2(TIMER);
  localparam logic [TW-1:0]   HALF_CNT  = TW'(half_count(TIMER));
  localparam logic [TW-1:0]   TIMER_MAX = TW'(TIMER - 1);
  localparam logic [TW-1:0]   TIMER_ONE = TW'(1);
  localparam logic [2:0]      LAST_DATA = 3'd7;
  localparam logic [2:0]      LAST_STOP = 3'(s - 1);
  localparam logic            PAR_EN    = (P != 0);
  localparam logic            PAR_SENSE = (EVEN_ODD != 0);

  // --------------------------------------------------------------------------
  // Input synchronizer
  // --------------------------------------------------------------------------
  logic rxs;

  sync_2ff u_sync_tdi (
    .clk   (clk),
    .reset (reset),
    .d     (tdi),
    .q     (rxs)
  );

  // --------------------------------------------------------------------------
  // Receiver state
  // --------------------------------------------------------------------------
  rx_state_e              state_q,   state_d;
  logic [TW-1:0]          timer_q,   timer_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q,   shift_d;
  logic                   f_perr_q,  f_perr_d;   // frame under reception: parity error
  logic                   f_ferr_q,  f_ferr_d;   // frame under reception: stop bit was 0
  logic                   f_hi_q,    f_hi_d;     // any 1 seen in data/parity/stop
  logic                   done_q,    done_d;     // frame completes next cycle
  logic                   bit_tick;

  // Holding register
  logic [DATA_BITS-1:0]   dout_q,       dout_d;
  logic                   valid_q,      valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q,  frame_err_d;
  logic                   overrun_q,    overrun_d;
  logic                   brk_q,        brk_d;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    timer_d   = (timer_q == TIMER_MAX) ? '0 : timer_q + TIMER_ONE;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    f_perr_d  = f_perr_q;
    f_ferr_d  = f_ferr_q;
    f_hi_d    = f_hi_q;
    done_d    = 1'b0;
    // After the start-bit sample the timer is realigned so that every later
    // bit centre falls on a timer value of zero.
    bit_tick  = (timer_q == '0);

    case (state_q)
      ST_IDLE: begin
        // The edge cycle itself counts as timer value 0, so the timer reads
        // HALF exactly HALF cycles after the line was first seen low.
        if (!rxs) begin
          state_d = ST_START;
          timer_d = TIMER_ONE;
        end else begin
          timer_d = '0;
        end
      end

      ST_START: begin
        if (timer_q == HALF_CNT) begin
          timer_d = TIMER_ONE;
          if (rxs) begin
            state_d = ST_IDLE;  // false start: line went back high
          end else begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            f_perr_d  = 1'b0;
            f_ferr_d  = 1'b0;
            f_hi_d    = 1'b0;
          end
        end
      end

      ST_DATA: begin
        if (bit_tick) begin
          shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
          f_hi_d    = f_hi_q | rxs;
          bit_cnt_d = bit_cnt_q + 3'd1;  // wraps to 0 after the last data bit
          if (bit_cnt_q == LAST_DATA) begin
            state_d = PAR_EN ? ST_PAR : ST_STOP;
          end
        end
      end

      ST_PAR: begin
        if (bit_tick) begin
          f_hi_d   = f_hi_q | rxs;
          f_perr_d = (rxs != parity_bit(shift_q, PAR_SENSE));
          state_d  = ST_STOP;
        end
      end

      ST_STOP: begin
        if (bit_tick) begin
          f_hi_d = f_hi_q | rxs;
          if (!rxs) begin
            f_ferr_d = 1'b1;
          end
          if (bit_cnt_q == LAST_STOP) begin
            done_d    = 1'b1;
            bit_cnt_d = '0;
            // A break leaves the line low; hold off until it returns high so
            // the continuing low level is not taken as a new start bit.
            state_d   = f_hi_d ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      ST_WAIT_HIGH: begin
        timer_d = '0;
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Holding register: completion loads unless an unconsumed byte is held and
  // is not being read on this very cycle, in which case the new frame drops.
  // --------------------------------------------------------------------------
  always_comb begin
    dout_d       = dout_q;
    valid_d      = valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    brk_d        = brk_q;

    if (done_q) begin
      if (!valid_q || rd) begin
        dout_d       = shift_q;
        valid_d      = 1'b1;
        parity_err_d = f_perr_q;
        frame_err_d  = f_ferr_q;
        brk_d        = ~f_hi_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rd && valid_q) begin
      valid_d      = 1'b0;
      overrun_d    = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      brk_d        = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      f_perr_q     <= 1'b0;
      f_ferr_q     <= 1'b0;
      f_hi_q       <= 1'b0;
      done_q       <= 1'b0;
      dout_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      brk_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      f_perr_q     <= f_perr_d;
      f_ferr_q     <= f_ferr_d;
      f_hi_q       <= f_hi_d;
      done_q       <= done_d;
      dout_q       <= dout_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      brk_q        <= brk_d;
    end
  end

  assign dout       = dout_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign brk        = brk_q;
  assign rx_tick    = done_q;

endmodule
`default_nettype wire
